// File: rtl/mario_pkg.sv
// Shared types and constants for the Mario sprite motion controller.
//   mario_state_e : motion FSM states, encoded as reported on state_out
//   Frame*        : animation frame indices into the 16x256 sprite sheet
//   FRAME_WORDS   : words per animation frame (16 x 32)
package mario_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWalk = 2'd1,
    StRise = 2'd2,
    StFall = 2'd3
  } mario_state_e;

  localparam logic [2:0] FrameIdle = 3'd0;
  localparam logic [2:0] FrameWalk = 3'd1;  // walk cycle occupies frames 1..3
  localparam logic [2:0] FrameRise = 3'd4;
  localparam logic [2:0] FrameFall = 3'd5;

  localparam logic [1:0] WalkStepLast = 2'd2;

  localparam int unsigned FRAME_WORDS = 512;

endpackage

// File: rtl/mario_motion_ctrl_if.sv
// Video-timing, button and sprite-output bundle of the Mario motion controller.
//   hcount_in/vcount_in : current pixel column/row
//   new_frame_in        : 1-cycle pulse at start of vblank
//   left_in/right_in/jump_in : player buttons (levels)
//   image_addr_out/in_sprite_out : registered sprite ROM address and box hit
//   x_out/y_out/state_out        : sprite position and motion state
// The controller uses the slave modport; the video/test side uses master.
interface mario_motion_ctrl_if;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        new_frame_in;
  logic        left_in;
  logic        right_in;
  logic        jump_in;
  logic [11:0] image_addr_out;
  logic        in_sprite_out;
  logic [10:0] x_out;
  logic [9:0]  y_out;
  logic [1:0]  state_out;

  modport master (
    output hcount_in, vcount_in, new_frame_in, left_in, right_in, jump_in,
    input  image_addr_out, in_sprite_out, x_out, y_out, state_out
  );

  modport slave (
    input  hcount_in, vcount_in, new_frame_in, left_in, right_in, jump_in,
    output image_addr_out, in_sprite_out, x_out, y_out, state_out
  );
endinterface

// File: rtl/mario_addr_gen.sv
// Registered pixel-to-sprite-address stage (1 cycle latency).
//   pixel_clk_in, rst_in      : clock, async active-high reset
//   hcount_in, vcount_in      : current pixel
//   x_in, y_in                : sprite top-left corner
//   facing_left_in            : mirror columns horizontally
//   frame_in                  : animation frame 0..7
//   image_addr_out            : {frame, row[4:0], col[3:0]} inside the box, else 0
//   in_sprite_out             : pixel lies inside the 16x32 box
module mario_addr_gen #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned FRAME_H = 32
) (
  input  logic        pixel_clk_in,
  input  logic        rst_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic [10:0] x_in,
  input  logic [9:0]  y_in,
  input  logic        facing_left_in,
  input  logic [2:0]  frame_in,
  output logic [11:0] image_addr_out,
  output logic        in_sprite_out
);

  localparam logic [11:0] ColLimit = 12'(WIDTH);
  localparam logic [10:0] RowLimit = 11'(FRAME_H);
  localparam logic [3:0]  ColLast  = 4'(WIDTH - 1);

  logic [11:0] col_diff;
  logic [10:0] row_diff;
  logic [3:0]  mcol;
  logic        hit;
  logic [11:0] image_addr_d, image_addr_q;
  logic        in_sprite_q;

  // One extra bit: pixels left of / above the sprite wrap to large values and fail the range test.
  always_comb begin
    col_diff     = {1'b0, hcount_in} - {1'b0, x_in};
    row_diff     = {1'b0, vcount_in} - {1'b0, y_in};
    hit          = (col_diff < ColLimit) && (row_diff < RowLimit);
    mcol         = facing_left_in ? (ColLast - col_diff[3:0]) : col_diff[3:0];
    image_addr_d = hit ? {frame_in, row_diff[4:0], mcol} : '0;
  end

  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      image_addr_q <= '0;
      in_sprite_q  <= 1'b0;
    end else begin
      image_addr_q <= image_addr_d;
      in_sprite_q  <= hit;
    end
  end

  assign image_addr_out = image_addr_q;
  assign in_sprite_out  = in_sprite_q;

endmodule

// File: rtl/mario_motion_ctrl.sv
// Per-frame Mario motion controller: walk/jump FSM, gravity, walk animation and
// the per-pixel sprite address stage.
//   pixel_clk_in : pixel clock (only clock)
//   rst_in       : asynchronous active-high reset
//   bus          : video timing, buttons and sprite outputs (slave modport)
// All motion state updates on the cycle where new_frame_in is high.
module mario_motion_ctrl
  import mario_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned FRAME_H  = 32,
  parameter int unsigned SCREEN_W = 1280,
  parameter int unsigned GROUND_Y = 688,
  parameter int unsigned WALK_SPD = 2,
  parameter int unsigned JUMP_VEL = 10,
  parameter int unsigned MAX_FALL = 8,
  parameter int unsigned ANIM_DIV = 6
) (
  input logic                pixel_clk_in,
  input logic                rst_in,
  mario_motion_ctrl_if.slave bus
);

  localparam logic [10:0]        XMax     = 11'(SCREEN_W - WIDTH);
  localparam logic [10:0]        XReset   = 11'((SCREEN_W - WIDTH) / 2);
  localparam logic [10:0]        XStep    = 11'(WALK_SPD);
  localparam logic [9:0]         YGround  = 10'(GROUND_Y);
  localparam logic signed [10:0] YGroundS = 11'(GROUND_Y);
  localparam logic signed [7:0]  JumpVel  = 8'(JUMP_VEL);
  localparam logic signed [7:0]  MaxFall  = 8'(MAX_FALL);
  localparam logic [2:0]         AnimLast = 3'(ANIM_DIV - 1);

  mario_state_e       state_q, state_d;
  logic [10:0]        x_q, x_d;
  logic [9:0]         y_q, y_d;
  logic signed [7:0]  vel_q, vel_d;
  logic               facing_left_q, facing_left_d;
  logic               jump_prev_q, jump_prev_d;
  logic [2:0]         anim_cnt_q, anim_cnt_d;
  logic [1:0]         walk_step_q, walk_step_d;

  logic               go_left, go_right, moving, jump_req;
  logic signed [7:0]  vel_inc, vel_fall;
  logic signed [10:0] y_ext, y_rise, y_fall;
  logic [2:0]         frame;

  always_comb begin
    go_right = bus.right_in & ~bus.left_in;
    go_left  = bus.left_in & ~bus.right_in;
    moving   = go_right | go_left;
    jump_req = bus.jump_in & ~jump_prev_q;

    y_ext    = signed'({1'b0, y_q});
    vel_inc  = vel_q + 8'sd1;
    vel_fall = (vel_q >= MaxFall) ? MaxFall : vel_inc;
    y_rise   = y_ext + signed'({{3{vel_q[7]}}, vel_q});
    y_fall   = y_ext + signed'({{3{vel_fall[7]}}, vel_fall});
  end

  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    vel_d         = vel_q;
    facing_left_d = facing_left_q;
    jump_prev_d   = jump_prev_q;
    anim_cnt_d    = anim_cnt_q;
    walk_step_d   = walk_step_q;

    if (bus.new_frame_in) begin
      jump_prev_d = bus.jump_in;

      if (go_left) begin
        facing_left_d = 1'b1;
        x_d           = (x_q <= XStep) ? '0 : x_q - XStep;
      end else if (go_right) begin
        facing_left_d = 1'b0;
        x_d           = (x_q >= XMax - XStep) ? XMax : x_q + XStep;
      end

      unique case (state_q)
        StIdle: begin
          if (jump_req) begin
            state_d = StRise;
            vel_d   = -JumpVel;
          end else if (moving) begin
            state_d     = StWalk;
            anim_cnt_d  = '0;
            walk_step_d = '0;
          end
        end
        StWalk: begin
          if (jump_req) begin
            state_d = StRise;
            vel_d   = -JumpVel;
          end else if (!moving) begin
            state_d = StIdle;
          end else if (anim_cnt_q == AnimLast) begin
            anim_cnt_d  = '0;
            walk_step_d = (walk_step_q == WalkStepLast) ? '0 : walk_step_q + 2'd1;
          end else begin
            anim_cnt_d = anim_cnt_q + 3'd1;
          end
        end
        StRise: begin
          if (y_rise[10]) begin
            // Hit the top of the screen: stop and start falling.
            y_d     = '0;
            vel_d   = '0;
            state_d = StFall;
          end else begin
            y_d   = y_rise[9:0];
            vel_d = vel_inc;
            if (!vel_inc[7]) state_d = StFall;
          end
        end
        StFall: begin
          if (y_fall >= YGroundS) begin
            y_d     = YGround;
            vel_d   = '0;
            state_d = moving ? StWalk : StIdle;
            if (moving) begin
              anim_cnt_d  = '0;
              walk_step_d = '0;
            end
          end else begin
            y_d   = y_fall[9:0];
            vel_d = vel_fall;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q       <= StIdle;
      x_q           <= XReset;
      y_q           <= YGround;
      vel_q         <= '0;
      facing_left_q <= 1'b0;
      jump_prev_q   <= 1'b0;
      anim_cnt_q    <= '0;
      walk_step_q   <= '0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      vel_q         <= vel_d;
      facing_left_q <= facing_left_d;
      jump_prev_q   <= jump_prev_d;
      anim_cnt_q    <= anim_cnt_d;
      walk_step_q   <= walk_step_d;
    end
  end

  always_comb begin
    unique case (state_q)
      StIdle:  frame = FrameIdle;
      StWalk:  frame = FrameWalk + {1'b0, walk_step_q};
      StRise:  frame = FrameRise;
      StFall:  frame = FrameFall;
      default: frame = FrameIdle;
    endcase
  end

  mario_addr_gen #(
    .WIDTH   (WIDTH),
    .FRAME_H (FRAME_H)
  ) u_addr_gen (
    .pixel_clk_in   (pixel_clk_in),
    .rst_in         (rst_in),
    .hcount_in      (bus.hcount_in),
    .vcount_in      (bus.vcount_in),
    .x_in           (x_q),
    .y_in           (y_q),
    .facing_left_in (facing_left_q),
    .frame_in       (frame),
    .image_addr_out (bus.image_addr_out),
    .in_sprite_out  (bus.in_sprite_out)
  );

  assign bus.x_out     = x_q;
  assign bus.y_out     = y_q;
  assign bus.state_out = state_q;

endmodule
